// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-port round-robin arbiter and sequencer in front of a single-ported
// data memory. Requests from requester 0 (load/store unit) and requester 1
// (debug/DMA loader) are serialised onto the memory address, read-enable,
// write-enable and the shared tri-state data bus. Each transaction takes
// three cycles: IDLE (sample and arbitrate), ACCESS (memory cycle) and
// RESP (one-cycle acknowledge with registered read data).
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   rN_req_i        requester N request level, held until ack
//   rN_we_i         requester N write (1) / read (0)
//   rN_addr_i       requester N byte address
//   rN_wdata_i      requester N write data
//   rN_ack_o        requester N one-cycle completion pulse
//   rN_err_o        requester N misaligned-access flag, valid with ack
//   rN_rdata_o      requester N read data, valid with ack
//   mem_addr_o      memory address (latched request address)
//   mem_re_o        memory read enable
//   mem_we_o        memory write enable
//   bus_io          shared 32-bit memory data bus, driven only while writing
module mem_arbiter #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r0_req_i,
  input  logic                  r0_we_i,
  input  logic [ADDR_WIDTH-1:0] r0_addr_i,
  input  logic [31:0]           r0_wdata_i,
  output logic                  r0_ack_o,
  output logic                  r0_err_o,
  output logic [31:0]           r0_rdata_o,
  input  logic                  r1_req_i,
  input  logic                  r1_we_i,
  input  logic [ADDR_WIDTH-1:0] r1_addr_i,
  input  logic [31:0]           r1_wdata_i,
  output logic                  r1_ack_o,
  output logic                  r1_err_o,
  output logic [31:0]           r1_rdata_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_re_o,
  output logic                  mem_we_o,
  inout  wire  [31:0]           bus_io
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state;
  state_t next_state;

  // last_grant doubles as the id of the transaction in flight: it is
  // updated with the winner at the same moment the request is latched.
  logic                  last_grant;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q;
  logic                  err_q;

  logic take;
  logic winner;
  logic drive;
  logic aligned;

  assign aligned = (addr_q[1:0] == 2'b00);

  // State register; reset forces IDLE so every state-decoded output
  // drops immediately when rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state, arbitration and state-decoded outputs. Outputs depend
  // only on registered state, never on the requester inputs.
  always_comb begin
    next_state = state;
    take       = 1'b0;
    winner     = 1'b0;
    mem_re_o   = 1'b0;
    mem_we_o   = 1'b0;
    drive      = 1'b0;
    r0_ack_o   = 1'b0;
    r1_ack_o   = 1'b0;
    case (state)
      IDLE: begin
        if (r0_req_i || r1_req_i) begin
          take       = 1'b1;
          next_state = ACCESS;
          // On a tie the requester that did not win last time goes first.
          if (r0_req_i && r1_req_i) begin
            winner = ~last_grant;
          end else begin
            winner = r1_req_i;
          end
        end
      end
      ACCESS: begin
        next_state = RESP;
        mem_re_o   = aligned & ~we_q;
        mem_we_o   = aligned & we_q;
        drive      = aligned & we_q;
      end
      RESP: begin
        next_state = IDLE;
        r0_ack_o   = ~last_grant;
        r1_ack_o   = last_grant;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Request latch and response capture. Read data is sampled from the bus
  // at the edge closing ACCESS; a misaligned access clears the response
  // data and raises err, while an aligned write leaves rdata untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (take) begin
        last_grant <= winner;
        addr_q     <= winner ? r1_addr_i  : r0_addr_i;
        we_q       <= winner ? r1_we_i    : r0_we_i;
        wdata_q    <= winner ? r1_wdata_i : r0_wdata_i;
      end
      if (state == ACCESS) begin
        if (!aligned) begin
          err_q   <= 1'b1;
          rdata_q <= '0;
        end else begin
          err_q <= 1'b0;
          if (!we_q) begin
            rdata_q <= bus_io;
          end
        end
      end
    end
  end

  assign mem_addr_o = addr_q;
  assign r0_rdata_o = rdata_q;
  assign r1_rdata_o = rdata_q;
  assign r0_err_o   = r0_ack_o & err_q;
  assign r1_err_o   = r1_ack_o & err_q;

  assign bus_io = drive ? wdata_q : {32{1'bz}};

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Two-port round-robin arbiter and sequencer in front of the single-ported data memory.
- Serialises read/write requests from requester 0 (load/store unit) and requester 1 (second master, e.g. debug/DMA loader) onto the memory's address, read-enable, write-enable and shared tri-state data bus.
- Drives the bus only during its own write cycle and returns read data through a registered response with a one-cycle acknowledge.

## Interface
- ADDR_WIDTH, default ADDR_WIDTH from constants package, memory byte-address width
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- r0_req_i  input  1  requester 0 request, level, held until ack
- r0_we_i  input  1  requester 0 write (1) / read (0)
- r0_addr_i  input  ADDR_WIDTH  requester 0 byte address
- r0_wdata_i  input  32  requester 0 write data
- r0_ack_o  output  1  requester 0 one-cycle completion pulse
- r0_err_o  output  1  requester 0 misaligned-access flag, valid with ack
- r0_rdata_o  output  32  requester 0 read data, valid with ack
- r1_*  same six signals for requester 1
- mem_addr_o  output  ADDR_WIDTH  memory address
- mem_re_o  output  1  memory read enable
- mem_we_o  output  1  memory write enable
- bus_io  inout  32  shared memory data bus (tri)

## Operation
- FSM states: IDLE, ACCESS, RESP; reset state IDLE.
- IDLE:
  - If no req is high, stay.
  - Otherwise select a winner. A single requester wins outright. If both are high, the requester not in last_grant wins.
  - Latch the winner's addr, we, wdata and id; update last_grant; go to ACCESS.
- ACCESS, lasts exactly one cycle, then RESP:
  - Aligned read (addr[1:0]==0, we=0): mem_re_o=1. Capture bus_io into the response data register at the closing edge.
  - Aligned write: mem_we_o=1; bus_io driven with latched wdata.
  - Misaligned: neither enable asserted; bus released; err flag set; response data = 0.
- RESP, lasts one cycle, then IDLE:
  - The granted requester's ack_o=1; its rdata_o and err_o are valid.
  - The other requester's ack_o=0.
- Requester rule:
  - Hold req, we, addr and wdata stable until ack.
  - Deassert req in the ack cycle, or it is taken as a new request in the following IDLE.
  - Inputs are sampled only in IDLE; changes during ACCESS/RESP are ignored.
- bus_io = latched wdata only when state==ACCESS, aligned and we=1; 'z in every other state, including reset.
- mem_addr_o = latched address register in all states (reset 0); no decode, no translation.
- rdata_o: one shared registered value fanned out to both ports, meaningful only with that port's ack; holds until the next read capture. A write completion leaves it unchanged.
- last_grant reset value = 1, so requester 0 wins the first tie.

## Timing
- Latency: req seen high in IDLE at cycle T → ACCESS at T+1 → ack at T+2. Minimum 3 cycles per transaction; back-to-back peak throughput is one access per 3 cycles.
- Memory read is combinational, so read data is valid on bus_io in the ACCESS cycle and is registered at its end.
- Memory write commits at the clock edge closing ACCESS.
- Reset values: state IDLE, last_grant 1; every output low/zero (mem_addr_o 0, mem_re_o 0, mem_we_o 0, acks 0, errs 0, rdata 0); bus_io released.
- Reset asserted mid-transaction:
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - Bus is released; the transaction is dropped with no ack.
  - A write interrupted in ACCESS is not guaranteed to commit.
- Starvation bound under continuous contention: ≤ 3 cycles extra, i.e. one other transaction.
- mem_re_o and mem_we_o are never high in the same cycle. No output toggles combinationally from requester inputs.

## Test plan
- Single read: memory word at 0x10 = 0xDEADBEEF; r0 reads 0x10 at cycle T → mem_re_o at T+1; r0_ack_o=1, r0_rdata_o=0xDEADBEEF, r0_err_o=0 at T+2; r1_ack_o stays 0.
- Write then read: r1 writes 0x12345678 to 0x20; bus_io carries the value only in ACCESS and is 'z otherwise. A subsequent r1 read of 0x20 returns 0x12345678.
- Contention fairness: both req held continuously after reset, each deasserting and reasserting around its ack. Grants alternate r0, r1, r0, r1 with acks spaced 3 cycles apart.
- Misaligned access: r0 writes to 0x22 → no mem_we_o pulse, bus stays 'z, r0_ack_o with r0_err_o=1, r0_rdata_o=0. Word at 0x20 is unchanged.
- Async reset mid-write: assert rst between edges during ACCESS → mem_we_o, acks and bus drive drop immediately; after release the FSM is in IDLE, r0 wins the first tie, and no stale ack is emitted.
- Held request: r0 keeps req high one cycle past ack → a second transaction is issued and a second ack follows 3 cycles later.
